// File: rtl/eth_miim_sequencer.sv
// MII management sequencer: Mdc generation, preamble/frame sequencing and shift-register strobes.
// Continuous scan support is compiled in only when ETH_MIIM_SCAN_EN is defined.
module eth_miim_sequencer #(
  parameter int unsigned PRE_LEN   = 32,
  parameter int unsigned FRAME_LEN = 32
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_divider,
  input  logic       i_no_pre,
  input  logic       i_wctrl_data,
  input  logic       i_rstat,
  input  logic       i_scan_stat,
  output logic       o_mdc,
  output logic       o_mdc_en,
  output logic       o_mdc_en_n,
  output logic [3:0] o_byte_select,
  output logic [1:0] o_latch_byte,
  output logic       o_write_op,
  output logic       o_mdo_oe,
  output logic       o_busy,
  output logic       o_wctrl_data_start,
  output logic       o_rstat_start,
  output logic       o_update_prsd,
  output logic       o_nvalid
);
  localparam logic [5:0] PreLast   = 6'(PRE_LEN - 1);
  localparam logic [5:0] FrameLast = 6'(FRAME_LEN - 1);
  localparam logic [5:0] TurnBit   = 6'd14;

  typedef enum logic [1:0] {StIdle, StPre, StFrame, StDone} state_e;

  state_e     r_state, w_state_d;
  logic [5:0] r_bit_cnt, w_bit_cnt_d;
  logic       r_write_op, w_write_op_d;
  logic [6:0] r_cnt, w_half_m1;
  logic       r_mdc, r_run;
  logic       w_mdc_en, w_mdc_en_n, w_accept;

  // Divisors below 2 behave as 2; odd divisors round down.
  assign w_half_m1 = (i_divider < 8'd2) ? 7'd0 : (i_divider[7:1] - 7'd1);

  // r_run holds off the first toggle so every output reads 0 straight out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 7'd0;
      r_mdc <= 1'b0;
      r_run <= 1'b0;
    end else if (!r_run) begin
      r_run <= 1'b1;
      r_cnt <= w_half_m1;
    end else if (r_cnt == 7'd0) begin
      r_cnt <= w_half_m1;
      r_mdc <= ~r_mdc;
    end else begin
      r_cnt <= r_cnt - 7'd1;
    end
  end

  assign w_mdc_en   = r_run & (r_cnt == 7'd0) & ~r_mdc;
  assign w_mdc_en_n = r_run & (r_cnt == 7'd0) & r_mdc;
  assign o_mdc      = r_mdc;
  assign o_mdc_en   = w_mdc_en;
  assign o_mdc_en_n = w_mdc_en_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_bit_cnt  <= 6'd0;
      r_write_op <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_bit_cnt  <= w_bit_cnt_d;
      r_write_op <= w_write_op_d;
    end
  end

  always_comb begin
    w_state_d          = r_state;
    w_bit_cnt_d        = r_bit_cnt;
    w_write_op_d       = r_write_op;
    w_accept           = 1'b0;
    o_byte_select      = 4'h0;
    o_latch_byte       = 2'b00;
    o_wctrl_data_start = 1'b0;
    o_rstat_start      = 1'b0;
    o_update_prsd      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_mdc_en_n) begin
          if (i_wctrl_data) begin
            w_accept           = 1'b1;
            o_wctrl_data_start = 1'b1;
            w_write_op_d       = 1'b1;
          end else if (i_rstat) begin
            w_accept      = 1'b1;
            o_rstat_start = 1'b1;
            w_write_op_d  = 1'b0;
          end
`ifdef ETH_MIIM_SCAN_EN
          else if (i_scan_stat) begin
            w_accept     = 1'b1;
            w_write_op_d = 1'b0;
          end
`endif
          if (w_accept) begin
            w_bit_cnt_d = 6'd0;
            if (i_no_pre) begin
              w_state_d     = StFrame;
              o_byte_select = 4'h1;
            end else begin
              w_state_d = StPre;
            end
          end
        end
      end
      StPre: begin
        if (w_mdc_en_n) begin
          if (r_bit_cnt == PreLast) begin
            o_byte_select = 4'h1;
            w_bit_cnt_d   = 6'd0;
            w_state_d     = StFrame;
          end else begin
            w_bit_cnt_d = r_bit_cnt + 6'd1;
          end
        end
      end
      StFrame: begin
        if (w_mdc_en_n) begin
          w_bit_cnt_d = r_bit_cnt + 6'd1;
          if (r_bit_cnt == 6'd7) o_byte_select = 4'h2;
          if (r_write_op && (r_bit_cnt == 6'd15)) o_byte_select = 4'h4;
          if (r_bit_cnt == 6'd23) begin
            if (r_write_op) o_byte_select = 4'h8;
            else            o_latch_byte  = 2'b10;
          end
          if (r_bit_cnt == FrameLast) begin
            if (!r_write_op) o_latch_byte = 2'b01;
            w_bit_cnt_d = 6'd0;
            w_state_d   = StDone;
          end
        end
      end
      StDone: begin
        o_update_prsd = ~r_write_op;
        w_state_d     = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Reads release the line from the turnaround bit onwards.
  assign o_mdo_oe   = (r_state == StPre) |
                      ((r_state == StFrame) & (r_write_op | (r_bit_cnt < TurnBit)));
  assign o_busy     = (r_state != StIdle) | w_accept;
  assign o_write_op = r_write_op;

`ifdef ETH_MIIM_SCAN_EN
  logic r_scan_op, r_scanning, r_nvalid;
  logic w_scan_acc;

  assign w_scan_acc = w_accept & ~i_wctrl_data & ~i_rstat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scan_op  <= 1'b0;
      r_scanning <= 1'b0;
      r_nvalid   <= 1'b0;
    end else begin
      if (w_accept) r_scan_op <= w_scan_acc;
      if (w_scan_acc && !r_scanning) begin
        r_scanning <= 1'b1;
        r_nvalid   <= 1'b1;
      end else if ((r_state == StDone) && r_scan_op) begin
        r_nvalid <= 1'b0;
        if (!i_scan_stat) r_scanning <= 1'b0;
      end
    end
  end

  assign o_nvalid = r_nvalid;
`else
  logic w_unused_scan;
  assign w_unused_scan = i_scan_stat;
  assign o_nvalid      = 1'b0;
`endif

endmodule

// File: tb/tb_eth_miim_sequencer.sv
// Self-checking bench for eth_miim_sequencer: frame-level event model checked every cycle,
// plus directed divider, write, read, priority, short-request and reset-abort scenarios.
module tb_eth_miim_sequencer;
  localparam int PreLen = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] divider;
  logic       no_pre, wctrl, rstat, scan;
  logic       mdc, mdc_en, mdc_en_n, write_op, mdo_oe, busy;
  logic       wstart, rstart, upd, nvalid;
  logic [3:0] byte_select;
  logic [1:0] latch_byte;

  int n_total = 0;
  int n_bad   = 0;

  // frame model: events are MdcEn_n cycles counted from the accept event
  bit m_active = 0, m_done = 0, m_write = 0;
  int m_s = 0, m_e = 0;

  int          oe_cnt, busy_cnt, upd_cnt, bs1_ev;
  int          start_q[$], bs_q[$], lb_q[$];
  logic [15:0] phy_data, prsd;
  logic [7:0]  sr;
  logic        p_mdc = 0, p_en = 0, p_en_n = 0;
  int          cyc, last_rise, per, hi;
  logic        q_mdc;

  eth_miim_sequencer #(.PRE_LEN(32), .FRAME_LEN(32)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_divider         (divider),
    .i_no_pre          (no_pre),
    .i_wctrl_data      (wctrl),
    .i_rstat           (rstat),
    .i_scan_stat       (scan),
    .o_mdc             (mdc),
    .o_mdc_en          (mdc_en),
    .o_mdc_en_n        (mdc_en_n),
    .o_byte_select     (byte_select),
    .o_latch_byte      (latch_byte),
    .o_write_op        (write_op),
    .o_mdo_oe          (mdo_oe),
    .o_busy            (busy),
    .o_wctrl_data_start(wstart),
    .o_rstat_start     (rstart),
    .o_update_prsd     (upd),
    .o_nvalid          (nvalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic       ev, e_oe, e_busy, e_ws, e_rs, e_up;
    logic [3:0] e_bs;
    logic [1:0] e_lb;
    int         n, b;
    if (!rst_n) begin
      check("reset_quiet", 32'({mdc, mdc_en, mdc_en_n, byte_select, latch_byte, write_op,
                                mdo_oe, busy, wstart, rstart, upd, nvalid}), 32'd0);
      m_active = 0;
      m_done   = 0;
      m_write  = 0;
    end else begin
      check("mdc_rise_follows_en", 32'(p_en), 32'(mdc & ~p_mdc));
      check("mdc_fall_follows_en_n", 32'(p_en_n), 32'(~mdc & p_mdc));
      ev = mdc_en_n;
      e_oe = 0; e_busy = 0; e_ws = 0; e_rs = 0; e_up = 0; e_bs = 4'h0; e_lb = 2'b00; n = 0;
      if (m_done) begin
        e_busy = 1;
        e_up   = ~m_write;
      end else if (m_active) begin
        e_busy = 1;
        e_oe   = (m_e < m_s) || m_write || ((m_e - m_s) < 14);
        if (ev) begin
          n = m_e + 1;
          if (n == m_s) e_bs = 4'h1;
          if (n == m_s + 8) e_bs = 4'h2;
          if (m_write && n == m_s + 16) e_bs = 4'h4;
          if (m_write && n == m_s + 24) e_bs = 4'h8;
          if (!m_write && n == m_s + 24) e_lb = 2'b10;
          if (!m_write && n == m_s + 32) e_lb = 2'b01;
        end
      end else if (ev && (wctrl || rstat)) begin
        e_ws   = wctrl;
        e_rs   = ~wctrl;
        e_busy = 1;
        e_bs   = no_pre ? 4'h1 : 4'h0;
      end
      check("byte_select", 32'(byte_select), 32'(e_bs));
      check("latch_byte", 32'(latch_byte), 32'(e_lb));
      check("mdo_oe", 32'(mdo_oe), 32'(e_oe));
      check("busy", 32'(busy), 32'(e_busy));
      check("wctrl_start", 32'(wstart), 32'(e_ws));
      check("rstat_start", 32'(rstart), 32'(e_rs));
      check("update_prsd", 32'(upd), 32'(e_up));
      check("write_op", 32'(write_op), 32'(m_write));
`ifndef ETH_MIIM_SCAN_EN
      check("nvalid", 32'(nvalid), 32'd0);
`endif
      if (mdo_oe) oe_cnt++;
      if (busy) busy_cnt++;
      if (upd) upd_cnt++;
      if (wstart) start_q.push_back(1);
      if (rstart) start_q.push_back(2);
      if (byte_select != 4'h0) begin
        bs_q.push_back(int'(byte_select));
        if (byte_select == 4'h1) bs1_ev = m_active ? m_e + 1 : 0;
      end
      if (latch_byte != 2'b00) lb_q.push_back(int'(latch_byte));
      if (m_active && ev) begin
        b  = m_e - m_s;  // frame bit clocked by this event
        sr = {sr[6:0], (b >= 16 && b <= 31) ? phy_data[31 - b] : 1'b0};
        if (latch_byte[1]) prsd[15:8] = sr;
        if (latch_byte[0]) prsd[7:0] = sr;
      end
      if (m_done) begin
        m_done = 0;
      end else if (m_active) begin
        if (ev) begin
          m_e = m_e + 1;
          if (m_e == m_s + 32) begin
            m_active = 0;
            m_done   = 1;
          end
        end
      end else if (ev && (wctrl || rstat)) begin
        m_active = 1;
        m_write  = wctrl;
        m_s      = no_pre ? 0 : PreLen;
        m_e      = 0;
      end
    end
    p_mdc  = mdc;
    p_en   = mdc_en;
    p_en_n = mdc_en_n;
  end

  always @(negedge clk) begin : meas
    if (!rst_n) begin
      cyc = 0; last_rise = 0; per = 0; hi = 0; q_mdc = 0;
    end else begin
      cyc++;
      if (mdc && !q_mdc) begin
        per       = cyc - last_rise;
        last_rise = cyc;
      end
      if (!mdc && q_mdc) hi = cyc - last_rise;
      q_mdc = mdc;
    end
  end

  task automatic clear_stats();
    oe_cnt = 0; busy_cnt = 0; upd_cnt = 0; bs1_ev = -1;
    start_q.delete(); bs_q.delete(); lb_q.delete();
    sr = 8'h00; prsd = 16'h0000;
  endtask

  task automatic wait_sig(input int sel, input int budget, input string name);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      #1;
      case (sel)
        0:       hit = wstart;
        1:       hit = rstart;
        2:       hit = !busy;
        3:       hit = mdc_en_n;
        default: hit = m_active && (m_e == m_s + 10);
      endcase
    end
    check({name, "_reached"}, 32'(hit), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; divider = 8'd8; no_pre = 0; wctrl = 0; rstat = 0; scan = 0;
    phy_data = 16'hA55A;
    clear_stats();
    repeat (3) @(negedge clk);
    #1 check("reset_mdc", 32'(mdc), 32'd0);
    @(posedge clk);
    #1 rst_n = 1;

    // Mdc period / duty for several divisors
    repeat (40) @(posedge clk);
    #1;
    check("div8_period", per, 8);
    check("div8_high", hi, 4);
    divider = 8'd0;
    repeat (20) @(posedge clk);
    #1 check("div0_period", per, 2);
    divider = 8'd1;
    repeat (20) @(posedge clk);
    #1 check("div1_period", per, 2);
    divider = 8'd9;
    repeat (40) @(posedge clk);
    #1;
    check("div9_period", per, 8);
    check("div9_high", hi, 4);

    // write with preamble
    divider = 8'd4;
    repeat (20) @(posedge clk);
    #1 clear_stats();
    wctrl = 1;
    wait_sig(0, 200, "wr_start");
    @(posedge clk);
    #1 wctrl = 0;
    wait_sig(2, 1000, "wr_idle");
    check("wr_oe_cycles", oe_cnt, 256);
    check("wr_busy_cycles", busy_cnt, 258);
    check("wr_bs_count", bs_q.size(), 4);
    check("wr_bs0", bs_q[0], 1);
    check("wr_bs1", bs_q[1], 2);
    check("wr_bs2", bs_q[2], 4);
    check("wr_bs3", bs_q[3], 8);
    check("wr_pre_events", bs1_ev, 32);
    check("wr_no_update", upd_cnt, 0);
    check("wr_no_latch", lb_q.size(), 0);

    // read without preamble, PHY returns A55A
    no_pre = 1;
    repeat (5) @(posedge clk);
    #1 clear_stats();
    rstat = 1;
    wait_sig(1, 200, "rd_start");
    @(posedge clk);
    #1 rstat = 0;
    wait_sig(2, 1000, "rd_idle");
    check("rd_oe_cycles", oe_cnt, 56);
    check("rd_busy_cycles", busy_cnt, 130);
    check("rd_bs_count", bs_q.size(), 2);
    check("rd_bs0", bs_q[0], 1);
    check("rd_bs1", bs_q[1], 2);
    check("rd_lb_count", lb_q.size(), 2);
    check("rd_lb0", lb_q[0], 2);
    check("rd_lb1", lb_q[1], 1);
    check("rd_update", upd_cnt, 1);
    check("rd_prsd", 32'(prsd), 32'h0000A55A);
    check("rd_write_op", 32'(write_op), 32'd0);

    // simultaneous write and read: write first, read after
    repeat (5) @(posedge clk);
    #1 clear_stats();
    wctrl = 1;
    rstat = 1;
    wait_sig(0, 200, "both_wstart");
    @(posedge clk);
    #1 wctrl = 0;
    wait_sig(1, 1000, "both_rstart");
    @(posedge clk);
    #1 rstat = 0;
    wait_sig(2, 1000, "both_idle");
    check("both_starts", start_q.size(), 2);
    check("both_first", start_q[0], 1);
    check("both_second", start_q[1], 2);
    check("both_update", upd_cnt, 1);
    check("both_bs_count", bs_q.size(), 6);

    // request withdrawn before any MdcEn_n
    divider = 8'd8;
    no_pre  = 0;
    repeat (20) @(posedge clk);
    wait_sig(3, 50, "short_align");
    @(posedge clk);
    #1 clear_stats();
    rstat = 1;
    repeat (3) @(posedge clk);
    #1 rstat = 0;
    repeat (30) @(posedge clk);
    #1;
    check("short_no_start", start_q.size(), 0);
    check("short_no_busy", busy_cnt, 0);

`ifndef ETH_MIIM_SCAN_EN
    clear_stats();
    scan = 1;
    repeat (40) @(posedge clk);
    #1 scan = 0;
    check("scan_no_start", start_q.size(), 0);
    check("scan_no_busy", busy_cnt, 0);
`endif

    // reset at frame bit 10 of a write, request kept high
    divider = 8'd4;
    repeat (10) @(posedge clk);
    #1 clear_stats();
    wctrl = 1;
    wait_sig(0, 200, "abort_start");
    wait_sig(4, 1000, "abort_bit10");
    rst_n = 0;
    #1;
    check("abort_mdc", 32'(mdc), 32'd0);
    check("abort_oe", 32'(mdo_oe), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    #3 rst_n = 1;
    clear_stats();
    wait_sig(0, 200, "restart_start");
    @(posedge clk);
    #1 wctrl = 0;
    wait_sig(2, 1000, "restart_idle");
    check("restart_pre_events", bs1_ev, 32);
    check("restart_oe_cycles", oe_cnt, 256);
    check("restart_starts", start_q.size(), 1);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
